// File: rtl/i2s_multichannel_tx.sv
// Multi-format (I2S / left-justified / TDM) serial audio transmitter with a one-frame holding buffer.
// BCLK and WS are derived from clk_in; data and WS only change on BCLK falling edges (divider ticks).
module i2s_multichannel_tx #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BCLK_DIV = 4,
    parameter int unsigned MODE     = 0
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         enable_in,
    input  logic [SAMPLE_W*CHANNELS-1:0] sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    output logic                         i2s_bclk_out,
    output logic                         i2s_ws_out,
    output logic                         i2s_d_out,
    output logic                         frame_start_out,
    output logic                         underrun_out
);
    localparam int unsigned FRAME_W    = SAMPLE_W * CHANNELS;
    localparam int unsigned FRAME_BITS = SLOT_W * CHANNELS;
    localparam int unsigned PAD_W      = SLOT_W - SAMPLE_W;
    localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0]    buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  ready_q, ready_d;
    logic                  bclk_q, bclk_d;
    logic                  ws_q, ws_d;
    logic                  d_q, d_d;
    logic                  fs_q, fs_d;
    logic                  ur_q, ur_d;

    logic [FRAME_BITS-1:0] padded_c;
    logic [FRAME_BITS-1:0] shift_src_c;
    logic [BIT_W-1:0]      bit_next_c;
    logic                  tick_c;
    logic                  accept_c;

    // Buffered frame laid out slot-major, each sample MSB-aligned in its slot with zero LSB padding.
    always_comb begin
        padded_c = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            padded_c[(CHANNELS-1-n)*SLOT_W + PAD_W +: SAMPLE_W] = buf_q[n*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        bclk_d      = 1'b0;
        ws_d        = 1'b0;
        d_d         = 1'b0;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        shift_src_c = shift_q;
        tick_c      = 1'b0;
        accept_c    = sample_valid_in && ready_q;
        bit_next_c  = (bit_cnt_q == BIT_W'(FRAME_BITS-1)) ? '0 : bit_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (enable_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tick_c    = (div_cnt_q == '0);
                div_cnt_d = (div_cnt_q == DIV_W'(BCLK_DIV-1)) ? '0 : div_cnt_q + 1'b1;
                bclk_d    = (div_cnt_q >= DIV_W'(BCLK_DIV/2));
                ws_d      = ws_q;
                d_d       = d_q;
                if (tick_c) begin
                    if ((bit_cnt_q == '0) && !enable_in) begin
                        // Stop only at a frame boundary; the held buffer survives for the next run.
                        state_d   = ST_IDLE;
                        div_cnt_d = '0;
                        bclk_d    = 1'b0;
                        ws_d      = 1'b0;
                        d_d       = 1'b0;
                    end else begin
                        if (bit_cnt_q == '0) begin
                            fs_d        = 1'b1;
                            ur_d        = !buf_full_q;
                            shift_src_c = buf_full_q ? padded_c : '0;
                            buf_full_d  = 1'b0;
                        end
                        d_d       = shift_src_c[FRAME_BITS-1];
                        shift_d   = shift_src_c << 1;
                        bit_cnt_d = bit_next_c;
                        if (MODE == 0) begin
                            ws_d = (bit_next_c >= BIT_W'(SLOT_W));
                        end else if (MODE == 1) begin
                            ws_d = (bit_cnt_q < BIT_W'(SLOT_W));
                        end else begin
                            ws_d = (bit_cnt_q == BIT_W'(FRAME_BITS-1));
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            buf_d      = sample_in;
            buf_full_d = 1'b1;
        end
        ready_d = !buf_full_d;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            bclk_q     <= 1'b0;
            ws_q       <= 1'b0;
            d_q        <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            bclk_q     <= bclk_d;
            ws_q       <= ws_d;
            d_q        <= d_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
        end
    end

    assign sample_ready_out = ready_q;
    assign i2s_bclk_out     = bclk_q;
    assign i2s_ws_out       = ws_q;
    assign i2s_d_out        = d_q;
    assign frame_start_out  = fs_q;
    assign underrun_out     = ur_q;

endmodule

// File: tb/tb_i2s_multichannel_tx.sv
// Directed bench for i2s_multichannel_tx: default I2S instance plus a 4-slot TDM instance.
module tb_i2s_multichannel_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, valid, ready, bclk, ws, d, fs, ur;
    logic [31:0] sample;
    logic        en2, valid2, ready2, bclk2, ws2, d2, fs2, ur2;
    logic [95:0] sample2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_multichannel_tx dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .enable_in       (en),
        .sample_in       (sample),
        .sample_valid_in (valid),
        .sample_ready_out(ready),
        .i2s_bclk_out    (bclk),
        .i2s_ws_out      (ws),
        .i2s_d_out       (d),
        .frame_start_out (fs),
        .underrun_out    (ur)
    );

    i2s_multichannel_tx #(
        .SAMPLE_W(24),
        .SLOT_W  (32),
        .CHANNELS(4),
        .BCLK_DIV(2),
        .MODE    (2)
    ) dut_tdm (
        .clk_in          (clk),
        .reset_in        (rst),
        .enable_in       (en2),
        .sample_in       (sample2),
        .sample_valid_in (valid2),
        .sample_ready_out(ready2),
        .i2s_bclk_out    (bclk2),
        .i2s_ws_out      (ws2),
        .i2s_d_out       (d2),
        .frame_start_out (fs2),
        .underrun_out    (ur2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of negedges until frame_start is seen, or limit+1 on timeout.
    task automatic wait_fs(input bit sel, input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((sel ? fs2 : fs) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Called on the frame_start negedge; collects one frame MSB-first and ends on the next frame's first cycle.
    task automatic capture(input bit sel, input int nbits, input int div, input int stop_bit,
                           output logic [127:0] dw, output logic [127:0] ww,
                           output logic [7:0] bw, output int urc);
        dw  = '0;
        ww  = '0;
        bw  = '0;
        urc = 0;
        for (int k = 0; k < nbits; k++) begin
            if (k == stop_bit) en = 1'b0;
            dw = {dw[126:0], (sel ? d2 : d)};
            ww = {ww[126:0], (sel ? ws2 : ws)};
            for (int c = 0; c < div; c++) begin
                if (k < 2) bw = {bw[6:0], (sel ? bclk2 : bclk)};
                if ((sel ? ur2 : ur) === 1'b1) urc++;
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    valid  = 1'b0;
                    valid2 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [127:0] dw;
        logic [127:0] ww;
        logic [7:0]   bw;
        logic [4:0]   acc;
        int           urc;
        int           n;

        rst = 1'b1; en = 1'b0; valid = 1'b0; sample = '0;
        en2 = 1'b0; valid2 = 1'b0; sample2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {ready, bclk, ws, d, fs, ur}, 6'b100000);
        chk("reset_outs_tdm", {ready2, bclk2, ws2, d2, fs2, ur2}, 6'b100000);
        rst = 1'b0;
        @(negedge clk);

        // Basic I2S frame pushed before the first frame
        sample = 32'h0F0F_A5F0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("t1_ready_full", ready, 1'b0);
        en = 1'b1;
        wait_fs(1'b0, 10, n);
        chk("t1_start_lat", n, 2);
        chk("t1_fs_ur", {fs, ur}, 2'b10);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t1_data", dw, 32'hA5F0_0F0F);
        chk("t1_ws", ww, 32'h0001_FFFE);
        chk("t1_bclk", bw, 8'h33);
        chk("t1_ur_cnt", urc, 0);

        // Underrun frame, then a normal frame
        chk("t2_fs_ur", {fs, ur}, 2'b11);
        sample = 32'h1234_C3A5; valid = 1'b1;
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t2_zero_data", dw, 0);
        chk("t2_ur_cnt", urc, 1);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t2_next_data", dw, 32'hC3A5_1234);
        chk("t2_next_ur_cnt", urc, 0);

        // Back-to-back frames with valid held
        sample = 32'h8001_7FFE; valid = 1'b1;
        @(negedge clk);
        chk("t3_ready_drop", ready, 1'b0);
        sample = 32'hFFFF_0001;
        repeat (8) @(negedge clk);
        chk("t3_f2_held", ready, 1'b0);
        wait_fs(1'b0, 200, n);
        chk("t3_wait_fs", n, 119);
        chk("t3_fs_no_ur", {fs, ur}, 2'b10);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t3_f1_data", dw, 32'h7FFE_8001);
        chk("t3_f1_ur", urc, 0);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t3_f2_data", dw, 32'h0001_FFFF);
        chk("t3_f2_ur", urc, 0);
        chk("t3_single_accept", {fs, ur}, 2'b11);

        // Stop at bit 10, frame completes, idle, restart with retained buffer
        sample = 32'h5A5A_3C3C; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_fs(1'b0, 200, n);
        chk("t5_wait_fs", n, 127);
        sample = 32'hDEAD_BEEF; valid = 1'b1;
        capture(1'b0, 32, 4, 10, dw, ww, bw, urc);
        chk("t5_data", dw, 32'h3C3C_5A5A);
        chk("t5_ws", ww, 32'h0001_FFFE);
        chk("t5_idle_outs", {bclk, ws, d, fs, ur}, 5'b00000);
        chk("t5_buf_retained", ready, 1'b0);
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= {bclk, ws, d, fs, ur};
        end
        chk("t5_idle_quiet", acc, 5'b00000);
        en = 1'b1;
        wait_fs(1'b0, 10, n);
        chk("t5_restart_lat", n, 2);
        chk("t5_restart_fs_ur", {fs, ur}, 2'b10);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t5_retained_data", dw, 32'hBEEF_DEAD);
        chk("t5_restart_bclk", bw, 8'h33);

        // Asynchronous reset in the middle of a frame
        sample = 32'h1111_2222; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("t6_async_clear", {ready, bclk, ws, d, fs, ur}, 6'b100000);
        en = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= {bclk, ws, d, fs, ur};
        end
        chk("t6_quiet", acc, 5'b00000);
        chk("t6_ready", ready, 1'b1);
        en = 1'b1;
        wait_fs(1'b0, 10, n);
        chk("t6_restart_lat", n, 2);
        chk("t6_buf_lost", {fs, ur}, 2'b11);
        capture(1'b0, 32, 4, -1, dw, ww, bw, urc);
        chk("t6_zero_data", dw, 0);
        en = 1'b0;

        // TDM, 4 slots of 32 bits with 24-bit samples, BCLK = clk/2
        sample2 = {24'h800004, 24'h800003, 24'h800002, 24'h800001};
        valid2  = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        chk("t4_ready_full", ready2, 1'b0);
        en2 = 1'b1;
        wait_fs(1'b1, 10, n);
        chk("t4_start_lat", n, 2);
        capture(1'b1, 128, 2, -1, dw, ww, bw, urc);
        chk("t4_data", dw, 128'h800001_00_800002_00_800003_00_800004_00);
        chk("t4_ws", ww, 128'h1);
        chk("t4_bclk", bw, 8'h05);
        chk("t4_ur_cnt", urc, 0);
        chk("t4_next_underrun", {fs2, ur2}, 2'b11);
        en2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
